// File: rtl/regfile_arb_pkg.sv
// Shared types and default widths for the register-file access arbiter.
package regfile_arb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the last-grant pointer moves only on an accepted request.
module rr_arbiter2
  import regfile_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Reset to requester 1 as last winner so requester 0 wins the first tie.
  req_id_t r_last;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = r_last ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (advance) begin
      r_last <= grant[1];
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates two requesters onto a single register-file port: accept, one access cycle, response.
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_write,
  input  logic [1:0]        req_byte,
  input  logic [ADDR_W-1:0] req_reg0,
  input  logic [ADDR_W-1:0] req_reg1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] rf_read_reg,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_reg_write,
  output logic              rf_byte_op
);

  state_t              r_state;
  state_t              w_next;
  req_id_t             r_owner;
  logic                r_write;
  logic                r_byte;
  logic [ADDR_W-1:0]   r_reg;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          w_grant;
  logic                w_accept;
  req_id_t             w_sel;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (w_accept),
    .grant   (w_grant)
  );

  assign w_sel = w_grant[1];

  // rst_n gates the accept path so req_ready is forced low while reset is held.
  always_comb begin
    w_next       = r_state;
    req_ready    = '0;
    rsp_valid    = '0;
    rf_reg_write = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_n && (w_grant != 2'b00)) begin
          req_ready = w_grant;
          w_accept  = 1'b1;
          w_next    = ACCESS;
        end
      end
      ACCESS: begin
        rf_reg_write = r_write && (r_reg != '0);
        w_next       = RESP;
      end
      RESP: begin
        rsp_valid[r_owner] = 1'b1;
        if (rsp_ready[r_owner]) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= 1'b0;
      r_write <= 1'b0;
      r_byte  <= 1'b0;
      r_reg   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_owner <= w_sel;
        r_write <= req_write[w_sel];
        r_byte  <= req_byte[w_sel];
        r_reg   <= w_sel ? req_reg1 : req_reg0;
        r_wdata <= w_sel ? req_wdata1 : req_wdata0;
      end
      if (r_state == ACCESS) begin
        if (r_write) begin
          r_rdata <= '0;
        end else if (r_byte) begin
          r_rdata <= {{(DATA_W-8){1'b0}}, rf_read_data[7:0]};
        end else begin
          r_rdata <= rf_read_data;
        end
      end
    end
  end

  assign rsp_rdata     = r_rdata;
  assign rf_read_reg   = r_reg;
  assign rf_write_reg  = r_reg;
  assign rf_write_data = r_wdata;
  assign rf_byte_op    = r_byte;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed self-checking bench for regfile_arbiter.
module tb_regfile_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [1:0]  req_byte;
  logic [4:0]  req_reg0;
  logic [4:0]  req_reg1;
  logic [31:0] req_wdata0;
  logic [31:0] req_wdata1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_rdata;
  logic [4:0]  rf_read_reg;
  logic [31:0] rf_read_data;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        rf_reg_write;
  logic        rf_byte_op;

  int tests;
  int fails;

  regfile_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_byte      (req_byte),
    .req_reg0      (req_reg0),
    .req_reg1      (req_reg1),
    .req_wdata0    (req_wdata0),
    .req_wdata1    (req_wdata1),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rf_read_reg   (rf_read_reg),
    .rf_read_data  (rf_read_data),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .rf_reg_write  (rf_reg_write),
    .rf_byte_op    (rf_byte_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; req_write = '0; req_byte = '0;
    req_reg0 = 5'd0; req_reg1 = 5'd0; req_wdata0 = '0; req_wdata1 = '0;
    rsp_ready = 2'b11; rf_read_data = '0;
    #2;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL rst_req_ready got %b exp 00", req_ready); end
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL rst_rsp_valid got %b exp 00", rsp_valid); end
    tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL rst_rsp_rdata got %h exp 0", rsp_rdata); end
    tests++; if ({rf_reg_write, rf_byte_op} !== 2'b00) begin fails++; $display("FAIL rst_rf_ctrl got %b exp 00", {rf_reg_write, rf_byte_op}); end
    tests++; if ({rf_read_reg, rf_write_reg, rf_write_data} !== 42'h0) begin fails++; $display("FAIL rst_rf_addr_data got %h exp 0", {rf_read_reg, rf_write_reg, rf_write_data}); end
    tick();
    rst_n = 1'b1;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL rst_favour0 got %b exp 01", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_write();
    req_valid = 2'b01; req_write = 2'b01; req_byte = 2'b00; req_reg0 = 5'd5; req_wdata0 = 32'hDEADBEEF;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL wr_accept got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00; req_reg0 = 5'd7; req_wdata0 = 32'h0;
    #1;
    tests++; if (rf_reg_write !== 1'b1) begin fails++; $display("FAIL wr_pulse got %b exp 1", rf_reg_write); end
    tests++; if (rf_write_reg !== 5'd5) begin fails++; $display("FAIL wr_reg got %0d exp 5", rf_write_reg); end
    tests++; if (rf_write_data !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_data got %h exp deadbeef", rf_write_data); end
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL wr_rsp_early got %b exp 00", rsp_valid); end
    tick();
    tests++; if (rf_reg_write !== 1'b0) begin fails++; $display("FAIL wr_pulse_end got %b exp 0", rf_reg_write); end
    tests++; if (rsp_valid !== 2'b01) begin fails++; $display("FAIL wr_rsp_valid got %b exp 01", rsp_valid); end
    tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL wr_rsp_rdata got %h exp 0", rsp_rdata); end
    tick();
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL wr_rsp_done got %b exp 00", rsp_valid); end
    tests++; if ({rf_write_reg, rf_write_data} !== {5'd5, 32'hDEADBEEF}) begin fails++; $display("FAIL wr_hold got %h exp %h", {rf_write_reg, rf_write_data}, {5'd5, 32'hDEADBEEF}); end
    req_write = 2'b00;
  endtask

  task automatic test_byte_read();
    req_valid = 2'b10; req_write = 2'b00; req_byte = 2'b10; req_reg1 = 5'd3; rf_read_data = 32'h12345678;
    #1;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL br_accept got %b exp 10", req_ready); end
    tick();
    req_valid = 2'b00; req_reg1 = 5'd9; req_byte = 2'b00;
    #1;
    tests++; if (rf_read_reg !== 5'd3) begin fails++; $display("FAIL br_reg got %0d exp 3", rf_read_reg); end
    tests++; if ({rf_byte_op, rf_reg_write} !== 2'b10) begin fails++; $display("FAIL br_ctrl got %b exp 10", {rf_byte_op, rf_reg_write}); end
    tick();
    tests++; if (rsp_valid !== 2'b10) begin fails++; $display("FAIL br_rsp_valid got %b exp 10", rsp_valid); end
    tests++; if (rsp_rdata !== 32'h00000078) begin fails++; $display("FAIL br_rdata got %h exp 00000078", rsp_rdata); end
    tick();
  endtask

  task automatic test_full_read();
    req_valid = 2'b01; req_write = 2'b00; req_byte = 2'b00; req_reg0 = 5'd4; rf_read_data = 32'h12345678;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL fr_accept got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    tests++; if (rsp_valid !== 2'b01) begin fails++; $display("FAIL fr_rsp_valid got %b exp 01", rsp_valid); end
    tests++; if (rsp_rdata !== 32'h12345678) begin fails++; $display("FAIL fr_rdata got %h exp 12345678", rsp_rdata); end
    tick();
  endtask

  task automatic test_r0_write();
    req_valid = 2'b10; req_write = 2'b10; req_byte = 2'b00; req_reg1 = 5'd0; req_wdata1 = 32'hFFFFFFFF;
    #1;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL r0_accept got %b exp 10", req_ready); end
    tick();
    req_valid = 2'b00;
    #1;
    tests++; if (rf_reg_write !== 1'b0) begin fails++; $display("FAIL r0_no_write got %b exp 0", rf_reg_write); end
    tests++; if (rf_write_reg !== 5'd0) begin fails++; $display("FAIL r0_reg got %0d exp 0", rf_write_reg); end
    tick();
    tests++; if (rsp_valid !== 2'b10) begin fails++; $display("FAIL r0_rsp_valid got %b exp 10", rsp_valid); end
    tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL r0_rdata got %h exp 0", rsp_rdata); end
    tick();
    req_write = 2'b00;
  endtask

  task automatic test_backpressure();
    req_valid = 2'b10; req_write = 2'b00; req_byte = 2'b00; req_reg1 = 5'd9;
    rf_read_data = 32'hA5A51234; rsp_ready = 2'b01;
    #1;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL bp_accept got %b exp 10", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    for (int i = 0; i < 5; i++) begin
      tests++; if (rsp_valid !== 2'b10) begin fails++; $display("FAIL bp_valid[%0d] got %b exp 10", i, rsp_valid); end
      tests++; if (rsp_rdata !== 32'hA5A51234) begin fails++; $display("FAIL bp_rdata[%0d] got %h exp a5a51234", i, rsp_rdata); end
      tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL bp_req_ready[%0d] got %b exp 00", i, req_ready); end
      rf_read_data = 32'h0BAD0000 + i;
      req_valid = 2'b01;
      tick();
    end
    req_valid = 2'b00; rsp_ready = 2'b11;
    #1;
    tests++; if (rsp_valid !== 2'b10) begin fails++; $display("FAIL bp_release got %b exp 10", rsp_valid); end
    tick();
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL bp_done got %b exp 00", rsp_valid); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_ready;
    logic [1:0] exp_valid;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = 2'b11; req_write = 2'b00; req_byte = 2'b00; req_reg0 = 5'd1; req_reg1 = 5'd2;
    rsp_ready = 2'b11; rf_read_data = 32'hCAFEF00D;
    #1;
    for (int k = 0; k < 12; k++) begin
      exp_ready = 2'b00;
      exp_valid = 2'b00;
      if (k % 3 == 0) exp_ready = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
      if (k % 3 == 2) exp_valid = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
      tests++; if (req_ready !== exp_ready) begin fails++; $display("FAIL cont_ready[%0d] got %b exp %b", k, req_ready, exp_ready); end
      tests++; if (rsp_valid !== exp_valid) begin fails++; $display("FAIL cont_valid[%0d] got %b exp %b", k, rsp_valid, exp_valid); end
      if (k % 3 == 2) begin
        tests++; if (rsp_rdata !== 32'hCAFEF00D) begin fails++; $display("FAIL cont_rdata[%0d] got %h exp cafef00d", k, rsp_rdata); end
      end
      tick();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_during_access();
    req_valid = 2'b01; req_write = 2'b01; req_byte = 2'b00; req_reg0 = 5'd7; req_wdata0 = 32'h11112222;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL ra_accept got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b11;
    tests++; if (rf_reg_write !== 1'b1) begin fails++; $display("FAIL ra_pulse got %b exp 1", rf_reg_write); end
    rst_n = 1'b0;
    #1;
    tests++; if (rf_reg_write !== 1'b0) begin fails++; $display("FAIL ra_pulse_drop got %b exp 0", rf_reg_write); end
    tests++; if ({req_ready, rsp_valid} !== 4'b0000) begin fails++; $display("FAIL ra_handshake got %b exp 0000", {req_ready, rsp_valid}); end
    tests++; if ({rf_write_reg, rf_write_data, rsp_rdata} !== 69'h0) begin fails++; $display("FAIL ra_cleared got %h exp 0", {rf_write_reg, rf_write_data, rsp_rdata}); end
    tick();
    req_valid = 2'b00;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if ({rsp_valid, rf_reg_write} !== 3'b000) begin fails++; $display("FAIL ra_no_rsp[%0d] got %b exp 000", i, {rsp_valid, rf_reg_write}); end
      tick();
    end
    req_valid = 2'b11;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL ra_favour0 got %b exp 01", req_ready); end
    req_valid = 2'b00; req_write = 2'b00;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_write();
    test_byte_read();
    test_full_read();
    test_r0_write();
    test_backpressure();
    test_contention();
    test_reset_during_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register index width (32 registers).
REQ-003 The block SHALL have port clk, input, 1, meaning single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, 2, meaning per-requester request valid (bit0 = core, bit1 = loader/debug).
REQ-006 The block SHALL have port req_ready, output, 2, meaning per-requester request accepted this cycle.
REQ-007 The block SHALL have ports req_write, input, 2 and req_byte, input, 2, meaning per-requester write-not-read and byte-operation selects.
REQ-008 The block SHALL have ports req_reg0/req_reg1, input, ADDR_W, and req_wdata0/req_wdata1, input, DATA_W, meaning register index and write data per requester.
REQ-009 The block SHALL have port rsp_valid, output, 2, and rsp_ready, input, 2, meaning per-requester response handshake.
REQ-010 The block SHALL have port rsp_rdata, output, DATA_W, meaning read data for the responding requester (0 for writes).
REQ-011 The block SHALL have register-file-side ports rf_read_reg (out, ADDR_W), rf_read_data (in, DATA_W), rf_write_reg (out, ADDR_W), rf_write_data (out, DATA_W), rf_reg_write (out, 1) and rf_byte_op (out, 1).

Function
REQ-012 The FSM SHALL have states IDLE, ACCESS, RESP; IDLE->ACCESS on accept, ACCESS->RESP unconditionally, RESP->IDLE when rsp_valid&rsp_ready of the owner.
REQ-013 req_ready[i] SHALL be 1 only in IDLE, only for the granted requester, and only when req_valid[i]=1; at most one bit set.
REQ-014 Arbitration SHALL be round-robin: when both valid, grant the requester not granted last; the pointer SHALL update only on an accepted handshake.
REQ-015 On accept, owner id, write, byte, reg and wdata SHALL be latched; later input changes SHALL be ignored until IDLE.
REQ-016 In ACCESS, rf_read_reg and rf_write_reg SHALL equal the latched reg, rf_byte_op the latched byte, and rf_write_data the latched wdata.
REQ-017 rf_reg_write SHALL pulse high for exactly the ACCESS cycle of a write, and SHALL stay 0 when the latched reg is 0 (r0 is read-only).
REQ-018 For reads, rf_read_data SHALL be captured at the end of ACCESS; for byte reads only bits [7:0] are kept, with the upper bits zero.
REQ-019 In RESP, rsp_valid[owner]=1 SHALL hold, with rsp_rdata stable, until rsp_ready[owner]=1; the other bit SHALL be 0.
REQ-020 Latency SHALL be accept in cycle N, rsp_valid in cycle N+2; peak throughput is one transaction per 3 cycles.
REQ-021 A requester held valid SHALL be granted within 2 arbitrations (no starvation).
REQ-022 Outside ACCESS, rf_reg_write SHALL be 0 and rf_* address and data outputs SHALL hold their last values.

Reset
REQ-023 Asserting rst_n=0 SHALL immediately force state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rf_reg_write=0, rf_byte_op=0, rf_* addresses and data to 0, and the round-robin pointer to favour requester 0.
REQ-024 Reset during ACCESS SHALL abort the transaction: no write pulse completes after rst_n falls, and no response is issued after release.

Structure
REQ-025 A package regfile_arb_pkg SHALL hold the state enum, the requester-id type and the DATA_W/ADDR_W defaults.
REQ-026 Grant logic SHALL be a sub-module rr_arbiter2 (inputs req[1:0] and advance; output grant[1:0]; internal last-grant pointer).

Verification
REQ-027 Write test: core writes reg 5 = 0xDEADBEEF at cycle N -> rf_reg_write=1 only at N+1 with reg 5 and that data; rsp_valid[0] at N+2 with rsp_rdata=0.
REQ-028 Byte read test: rf_read_data=0x12345678 and a byte read of reg 3 -> rsp_rdata=0x00000078.
REQ-029 Contention test: both requesters valid continuously from reset -> grants alternate 0,1,0,1 and each requester gets a response every 6 cycles.
REQ-030 r0 write test: loader writes reg 0 = 0xFFFFFFFF -> rf_reg_write stays 0 and a response is still issued.
REQ-031 Backpressure test: rsp_ready[1]=0 for 5 cycles -> rsp_valid[1] and rsp_rdata stay stable and req_ready stays 0 throughout.
REQ-032 Reset test: rst_n low during ACCESS of a write -> rf_reg_write drops immediately; after release the state is IDLE with no response and requester 0 is favoured.
